// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the MEM stage.
//
// A request is accepted in IDLE on start_i. Multiplies and regular divides
// spend 32 cycles in CALC (one shift-add or restoring step per cycle), then
// one cycle in DONE with done_o high. Divide-by-zero and signed overflow
// skip CALC and go straight to DONE. All arithmetic runs on unsigned
// magnitudes; signs are reapplied only when the result is registered.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start_i
//   CALC  | 32 iteration cycles, busy_o high
//   DONE  | result_o valid, done_o high for one cycle
//
// Ports:
//   clk_i     in   1   rising-edge clock
//   reset_i   in   1   synchronous active-high reset
//   start_i   in   1   request strobe
//   op_i      in   3   RV32M funct3
//   a_i       in   32  rs1 operand
//   b_i       in   32  rs2 operand
//   busy_o    out  1   stall request, high while in CALC
//   done_o    out  1   result-valid pulse, high while in DONE
//   result_o  out  32  result, held until the next DONE or reset

module mul_div_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_neg_res;   // operand signs differ: negate product / quotient
  logic        r_neg_rem;   // dividend negative: negate remainder
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  // Request decode on the raw inputs (used only at the acceptance edge)
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_fast_res;

  assign w_a_signed = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010) ||
                      (op_i == 3'b100) || (op_i == 3'b110);
  assign w_b_signed = (op_i == 3'b000) || (op_i == 3'b001) ||
                      (op_i == 3'b100) || (op_i == 3'b110);
  assign w_a_neg    = w_a_signed & a_i[31];
  assign w_b_neg    = w_b_signed & b_i[31];
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude
  assign w_a_mag    = w_a_neg ? (~a_i + 32'd1) : a_i;
  assign w_b_mag    = w_b_neg ? (~b_i + 32'd1) : b_i;

  assign w_div_zero = op_i[2] && (b_i == 32'd0);
  assign w_div_ovf  = op_i[2] && !op_i[0] &&
                      (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // op_i[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_fast_res = 32'd0;
    if (w_div_zero) begin
      w_fast_res = op_i[1] ? a_i : 32'hFFFF_FFFF;
    end else begin
      w_fast_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step; both datapaths advance every CALC cycle and the
  // latched op picks which one is used at the end.
  logic [63:0] w_acc_nxt;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh   = {r_rem, r_quo[31]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_divisor});
  // When w_ge holds the true difference is below the divisor, so a 32-bit
  // modular subtract is exact.
  assign w_rem_diff = w_rem_sh[31:0] - r_divisor;
  assign w_rem_nxt  = w_ge ? w_rem_diff : w_rem_sh[31:0];
  assign w_quo_nxt  = {r_quo[30:0], w_ge};

  // Sign correction of the final step
  logic [63:0] w_prod_s;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_calc_res;

  assign w_prod_s = r_neg_res ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
  assign w_quo_s  = r_neg_res ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
  assign w_rem_s  = r_neg_rem ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  always_comb begin
    w_calc_res = 32'd0;
    case (r_op)
      3'b000:                 w_calc_res = w_prod_s[31:0];
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod_s[63:32];
      3'b100, 3'b101:         w_calc_res = w_quo_s;
      default:                w_calc_res = w_rem_s;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 5'd0;
      r_op      <= 3'd0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_acc     <= 64'd0;
      r_quo     <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_op      <= op_i;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_mcand   <= {32'd0, w_a_mag};
            r_mplier  <= w_b_mag;
            r_acc     <= 64'd0;
            r_quo     <= w_a_mag;
            r_rem     <= 32'd0;
            r_divisor <= w_b_mag;
            r_cnt     <= 5'd0;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_fast_res;
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
            end else begin
              r_state  <= ST_CALC;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_quo    <= w_quo_nxt;
          r_rem    <= w_rem_nxt;
          if (r_cnt == 5'd31) begin
            r_result <= w_calc_res;
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed, table-driven bench for mul_div_unit.
// Each vector is started from IDLE and checked for result, latency to done_o,
// number of busy cycles and result hold afterwards. Hand-written sequences
// cover reset abort, start ignored during CALC and back-to-back starts.

module tb_mul_div_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_pass = 0;
  int n_chk  = 0;

  mul_div_unit dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Counts negedges after the acceptance edge until done_o is seen.
  task automatic wait_done(input int limit, output int lat, output int nbusy, output logic got);
    lat = 0; nbusy = 0; got = 1'b0;
    for (int i = 1; i <= limit && !got; i++) begin
      @(negedge clk_i);
      if (busy_o) nbusy++;
      if (done_o) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    int   lat, nbusy, ndone, pre_busy;
    logic got;

    vecs.push_back('{OP_MUL,    32'd7,          32'd6,          32'h0000_002A, 1'b0, "mul_7x6"});
    vecs.push_back('{OP_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0, "mul_m3x5"});
    vecs.push_back('{OP_MUL,    32'd0,          32'd5,          32'h0000_0000, 1'b0, "mul_zero"});
    vecs.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, "mulh_ff"});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, "mulhsu_ff"});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, "mulhu_ff"});
    vecs.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 1'b0, "mulh_min"});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0, "div_m7_2"});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0, "rem_m7_2"});
    vecs.push_back('{OP_DIVU,   32'd100,        32'd7,          32'h0000_000E, 1'b0, "divu_100_7"});
    vecs.push_back('{OP_REMU,   32'd100,        32'd7,          32'h0000_0002, 1'b0, "remu_100_7"});
    vecs.push_back('{OP_DIV,    32'd100,        32'd3,          32'h0000_0021, 1'b0, "div_100_3"});
    vecs.push_back('{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, "divu_by0"});
    vecs.push_back('{OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, "div_by0"});
    vecs.push_back('{OP_REM,    32'd5,          32'd0,          32'h0000_0005, 1'b1, "rem_by0"});
    vecs.push_back('{OP_REMU,   32'h1234_5678,  32'd0,          32'h1234_5678, 1'b1, "remu_by0"});
    vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, "div_ovf"});
    vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1, "rem_ovf"});

    reset_i = 1'b1; start_i = 1'b0; op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("reset_busy",   {31'd0, busy_o}, 32'd0);
    chk("reset_done",   {31'd0, done_o}, 32'd0);
    chk("reset_result", result_o,        32'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(40, lat, nbusy, got);
      chk({vecs[i].name, "_done_seen"}, {31'd0, got}, 32'd1);
      chk({vecs[i].name, "_result"},    result_o,     vecs[i].exp);
      chk({vecs[i].name, "_latency"},   lat,          vecs[i].fast ? 32'd1 : 32'd33);
      chk({vecs[i].name, "_busy_cyc"},  nbusy,        vecs[i].fast ? 32'd0 : 32'd32);
      @(negedge clk_i);
      chk({vecs[i].name, "_idle_done"}, {31'd0, done_o}, 32'd0);
      chk({vecs[i].name, "_hold"},      result_o,        vecs[i].exp);
    end

    // Reset in CALC cycle 10 aborts with no done pulse; result_o was 0 before
    // only if reset clears it, since the last vector left a nonzero value.
    start_op(OP_MUL, 32'd3, 32'd3);
    wait_done(40, lat, nbusy, got);
    chk("pre_abort_result", result_o, 32'd9);
    start_op(OP_DIV, 32'd100, 32'd3);
    repeat (10) @(negedge clk_i);
    chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy",   {31'd0, busy_o}, 32'd0);
    chk("abort_result", result_o,        32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);

    // start_i during CALC with other operands is ignored
    start_op(OP_MUL, 32'd7, 32'd6);
    pre_busy = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (busy_o) pre_busy++;
    end
    op_i = OP_DIVU; a_i = 32'd1; b_i = 32'd0; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(40, lat, nbusy, got);
    chk("ignore_done_seen", {31'd0, got}, 32'd1);
    chk("ignore_result",    result_o,     32'h0000_002A);
    chk("ignore_latency",   5 + lat,      32'd33);
    chk("ignore_busy_cyc",  pre_busy + nbusy, 32'd32);

    // start_i held through DONE is only taken on return to IDLE
    @(negedge clk_i);
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk_i);
    wait_done(40, lat, nbusy, got);
    chk("b2b_first_done",    {31'd0, got}, 32'd1);
    chk("b2b_first_latency", lat,          32'd33);
    chk("b2b_first_result",  result_o,     32'h0000_000E);
    @(negedge clk_i);
    chk("b2b_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("b2b_idle_done", {31'd0, done_o}, 32'd0);
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(40, lat, nbusy, got);
    chk("b2b_second_done",    {31'd0, got}, 32'd1);
    chk("b2b_second_latency", lat,          32'd33);
    chk("b2b_second_busy",    nbusy,        32'd32);
    chk("b2b_second_result",  result_o,     32'h0000_000E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
